pipe_mem_stage: RTL and testbench

Memory stage of the five-stage pipelined computer. Consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn), performs the data-memory access over a req/ack port that may insert wait states, and registers the MEM/WB values for write-back. When the memory is slow, it raises stall to freeze the upstream stages. An optional one-entry store buffer lets stores retire without waiting.

---
 rtl/pipe_mem_pkg.sv | 16 +
 rtl/pipe_store_buf.sv | 44 ++++
 rtl/pipe_mem_stage.sv | 169 ++++++++++++++++
 tb/tb_pipe_mem_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the pipeline memory stage: state encoding, default
// address width and the word-match slice bounds used by the store buffer.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } mem_state_e;

    localparam int ADDR_BITS_DEF = 32;

    // Word match ignores the byte offset bits below MATCH_LSB.
    localparam int MATCH_LSB = 2;

endpackage

// File: rtl/pipe_store_buf.sv
// One-entry store buffer: holds a pending store (addr/data) and reports a
// word-address match for load forwarding. Capture wins over clear on one edge.
module pipe_store_buf
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          cap_i,
    input  logic                          clr_i,
    input  logic [ADDR_BITS-1:0]          cap_addr_i,
    input  logic [31:0]                   cap_data_i,
    input  logic [ADDR_BITS-1:MATCH_LSB]  lookup_i,
    output logic                          full_o,
    output logic [ADDR_BITS-1:0]          addr_o,
    output logic [31:0]                   data_o,
    output logic                          match_o
);

    logic                 full_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          data_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (cap_i) begin
            full_q <= 1'b1;
            addr_q <= cap_addr_i;
            data_q <= cap_data_i;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign match_o = full_q && (addr_q[ADDR_BITS-1:MATCH_LSB] == lookup_i);

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage of the five-stage pipeline: data-memory access over req/ack with
// stall, plus the MEM/WB register. STORE_BUF_EN adds a one-entry store buffer.
module pipe_mem_stage
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 mwreg,
    input  logic                 mm2reg,
    input  logic                 mwmem,
    input  logic [31:0]          malu,
    input  logic [31:0]          mb,
    input  logic [4:0]           mrn,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [ADDR_BITS-1:0] dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata,
    output logic                 stall,
    output logic                 wwreg,
    output logic                 wm2reg,
    output logic [31:0]          wmo,
    output logic [31:0]          walu,
    output logic [4:0]           wrn,
    output mem_state_e           dbg_state
);

    mem_state_e state_q, state_d;

    logic                 drain_req;
    logic                 direct_req;
    logic                 m_done;
    logic                 req_we;
    logic [ADDR_BITS-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic [31:0]          load_data;

`ifdef STORE_BUF_EN
    logic                 buf_cap;
    logic                 buf_clr;
    logic                 buf_full;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [31:0]          buf_data;
    logic                 buf_match;
    logic                 fwd_sel;

    pipe_store_buf #(.ADDR_BITS(ADDR_BITS)) u_store_buf (
        .clock      (clock),
        .resetn     (resetn),
        .cap_i      (buf_cap),
        .clr_i      (buf_clr),
        .cap_addr_i (malu[ADDR_BITS-1:0]),
        .cap_data_i (mb),
        .lookup_i   (malu[ADDR_BITS-1:MATCH_LSB]),
        .full_o     (buf_full),
        .addr_o     (buf_addr),
        .data_o     (buf_data),
        .match_o    (buf_match)
    );

    // A full buffer always drains; the M instruction decides around it.
    always_comb begin
        drain_req  = buf_full;
        direct_req = 1'b0;
        buf_cap    = 1'b0;
        fwd_sel    = 1'b0;
        m_done     = 1'b1;
        if (mwmem) begin
            buf_cap = !buf_full || dm_ack;
            m_done  = buf_cap;
        end else if (mm2reg) begin
            if (!buf_full) begin
                direct_req = 1'b1;
                m_done     = dm_ack;
            end else begin
                fwd_sel = buf_match;
                m_done  = buf_match;
            end
        end
        req_we    = drain_req ? 1'b1     : mwmem;
        req_addr  = drain_req ? buf_addr : malu[ADDR_BITS-1:0];
        req_wdata = drain_req ? buf_data : mb;
        load_data = fwd_sel   ? buf_data : dm_rdata;
    end

    assign buf_clr = drain_req && dm_ack;
`else
    always_comb begin
        drain_req  = 1'b0;
        direct_req = mm2reg || mwmem;
        m_done     = !direct_req || dm_ack;
        req_we     = mwmem;
        req_addr   = malu[ADDR_BITS-1:0];
        req_wdata  = mb;
        load_data  = dm_rdata;
    end
`endif

    // Reset gates the port immediately so an abandoned access is dropped.
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        stall    = 1'b0;
        if (resetn) begin
            dm_req   = drain_req || direct_req;
            dm_we    = req_we;
            dm_addr  = req_addr;
            dm_wdata = req_wdata;
            stall    = !m_done;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (drain_req && !dm_ack) begin
            state_d = DRAIN;
        end else if (direct_req && !dm_ack) begin
            state_d = BUSY;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    logic        wwreg_q, wm2reg_q;
    logic [31:0] wmo_q, walu_q;
    logic [4:0]  wrn_q;

    // A stalled edge inserts a bubble into W and leaves the data fields alone.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= '0;
            walu_q   <= '0;
            wrn_q    <= '0;
        end else if (stall) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
        end else begin
            wwreg_q  <= mwreg;
            wm2reg_q <= mm2reg;
            walu_q   <= malu;
            wrn_q    <= mrn;
            if (mm2reg) begin
                wmo_q <= load_data;
            end
        end
    end

    assign wwreg  = wwreg_q;
    assign wm2reg = wm2reg_q;
    assign wmo    = wmo_q;
    assign walu   = walu_q;
    assign wrn    = wrn_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage; W-stage results go through an expected
// queue checked by an independent monitor. Buffer cases need STORE_BUF_EN.
module tb_pipe_mem_stage;
    import pipe_mem_pkg::*;

    localparam int W = 70;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall, wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
    mem_state_e  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  last_wmo = '0;

    pipe_mem_stage #(.ADDR_BITS(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .stall     (stall),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bubble();
        mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        malu = '0; mb = '0; mrn = '0;
        dm_ack = 1'b0; dm_rdata = '0;
    endtask

    // Drive one M instruction from posedge+1 until it retires; memory acks
    // after `waits` cycles.
    task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input int waits, input logic [31:0] rdata);
        logic mem;
        mem = m2reg | wmem;
        mwreg = wreg; mm2reg = m2reg; mwmem = wmem;
        malu = alu; mb = b; mrn = rn;
        if (m2reg) last_wmo = rdata;
        if (wreg) exp_q.push_back({m2reg, rn, alu, last_wmo});
        for (int i = 0; i <= waits; i++) begin
            dm_ack   = mem && (i == waits);
            dm_rdata = (i == waits) ? rdata : 32'hFFFF_0000;
            @(negedge clock);
            check("stall", {69'd0, stall}, {69'd0, mem && (i < waits)});
            if (i > 0) check("w_bubble_on_stall", {68'd0, wwreg, wm2reg}, '0);
            if (mem) begin
                check("req_we_addr", {36'd0, dm_req, dm_we, dm_addr}, {36'd0, 1'b1, wmem, alu});
                if (wmem) check("wdata", {38'd0, dm_wdata}, {38'd0, b});
            end else begin
                check("no_req", {69'd0, dm_req}, '0);
            end
            @(posedge clock); #1;
        end
        bubble();
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (resetn === 1'b1 && wwreg === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w_unexpected: got wrn=%0d walu=%0h wmo=%0h expected no write-back", wrn, walu, wmo);
            end else begin
                e = exp_q.pop_front();
                check("w_out", {wm2reg, wrn, walu, wmo}, e);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        resetn = 1'b0;
        bubble();
        repeat (2) @(posedge clock);
        #1;
        check("reset_port", {1'd0, dm_req, dm_we, dm_addr, dm_wdata, stall}, '0);
        check("reset_w", {wwreg, wm2reg, wmo, walu, wrn}, '0);
        check("reset_state", {68'd0, dbg_state}, {68'd0, IDLE});
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;

        issue(1, 1, 0, 32'h0000_0100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);
        issue(1, 0, 0, 32'h0000_1234, 32'h0, 5'd9, 0, 32'h0);
        issue(1, 1, 0, 32'h0000_0104, 32'h0, 5'd6, 3, 32'h1234_5678);

`ifndef STORE_BUF_EN
        issue(0, 0, 1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 2, 32'h0);
        @(negedge clock);
        check("store_w_bubble", {68'd0, wwreg, wm2reg}, '0);
        @(posedge clock); #1;
`else
        mwmem = 1'b1; malu = 32'h40; mb = 32'h55;
        @(negedge clock);
        check("buf_capture", {68'd0, stall, dm_req}, '0);
        @(posedge clock); #1;
        mwmem = 1'b0; mwreg = 1'b1; mm2reg = 1'b1; malu = 32'h40; mb = 32'h0; mrn = 5'd7;
        last_wmo = 32'h55;
        exp_q.push_back({1'b1, 5'd7, 32'h40, 32'h55});
        @(negedge clock);
        check("fwd_no_stall", {69'd0, stall}, '0);
        check("drain_req", {4'd0, dm_req, dm_we, dm_addr, dm_wdata}, {4'd0, 1'b1, 1'b1, 32'h40, 32'h55});
        @(posedge clock); #1;
        bubble();
        @(negedge clock);
        check("drain_state", {68'd0, dbg_state}, {68'd0, DRAIN});
        check("drain_hold", {4'd0, dm_req, dm_we, dm_addr, dm_wdata}, {4'd0, 1'b1, 1'b1, 32'h40, 32'h55});
        @(posedge clock); #1;
        dm_ack = 1'b1;
        @(negedge clock);
        check("drain_ack", {4'd0, dm_req, dm_we, dm_addr, dm_wdata}, {4'd0, 1'b1, 1'b1, 32'h40, 32'h55});
        @(posedge clock); #1;
        dm_ack = 1'b0;
        @(negedge clock);
        check("buf_empty", {69'd0, dm_req}, '0);
        @(posedge clock); #1;

        mwmem = 1'b1; malu = 32'h40; mb = 32'h99;
        @(negedge clock);
        check("buf_capture2", {68'd0, stall, dm_req}, '0);
        @(posedge clock); #1;
        mwmem = 1'b0; mwreg = 1'b1; mm2reg = 1'b1; malu = 32'h80; mb = 32'h0; mrn = 5'd8;
        @(negedge clock);
        check("miss_stall_drain", {36'd0, stall, dm_we, dm_addr}, {36'd0, 1'b1, 1'b1, 32'h40});
        @(posedge clock); #1;
        dm_ack = 1'b1;
        @(negedge clock);
        check("miss_stall_ack", {4'd0, stall, dm_we, dm_addr, dm_wdata}, {4'd0, 1'b1, 1'b1, 32'h40, 32'h99});
        @(posedge clock); #1;
        dm_rdata = 32'hCAFE_F00D;
        last_wmo = 32'hCAFE_F00D;
        exp_q.push_back({1'b1, 5'd8, 32'h80, 32'hCAFE_F00D});
        @(negedge clock);
        check("miss_load_issue", {35'd0, stall, dm_req, dm_we, dm_addr}, {35'd0, 1'b0, 1'b1, 1'b0, 32'h80});
        @(posedge clock); #1;
        bubble();
`endif

        issue(1, 1, 0, 32'h0000_03FC, 32'h0, 5'd31, 1, 32'h0BAD_F00D);

        // Reset in the middle of an outstanding load.
        mwreg = 1'b1; mm2reg = 1'b1; malu = 32'h500; mrn = 5'd3; dm_ack = 1'b0;
        @(negedge clock);
        check("busy_req", {68'd0, stall, dm_req}, {68'd0, 1'b1, 1'b1});
        @(posedge clock); #1;
        check("busy_state", {68'd0, dbg_state}, {68'd0, BUSY});
        #3 resetn = 1'b0;
        #1;
        check("rst_async_port", {68'd0, dm_req, stall}, '0);
        check("rst_async_w", {wwreg, wm2reg, wmo, walu, wrn}, '0);
        check("rst_async_state", {68'd0, dbg_state}, {68'd0, IDLE});
        bubble();
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clock) resetn = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("late_ack_ignored", {34'd0, dm_req, stall, wwreg, wmo, dbg_state},
                  {34'd0, 1'b0, 1'b0, 1'b0, 32'h0, IDLE});
        end
        @(posedge clock); #1;
        dm_ack = 1'b0;

        issue(1, 1, 0, 32'h0000_0600, 32'h0, 5'd12, 2, 32'h7777_1111);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("queue_drained", {38'd0, 32'(exp_q.size())}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
